// File: rtl/rmt_recovery_ctrl_pkg.sv
// Shared types and constants for the RMT recovery controller slice.
package rmt_recovery_ctrl_pkg;

    // Number of RMT write ports taken over during an AMT->RMT copy.
    localparam int RMT_WR_PORTS = 4;

    // Controller states: normal rename forwarding, or copying the AMT.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } rmt_state_e;

    // Width of the beat counter: ceil(log2(depth/ports)), never below 1.
    function automatic int beat_bits(input int depth);
        int beats;
        beats = depth / RMT_WR_PORTS;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/rmt_recovery_ctrl_wr_mux.sv
// One RMT write port: selects the rename write or the AMT copy write,
// and can block the write entirely.
module rmt_wr_mux
    import rmt_recovery_ctrl_pkg::*;
#(
    parameter int SRAM_INDEX = 4,
    parameter int SRAM_WIDTH = 8
) (
    input  logic                  copy_sel,
    input  logic                  wr_block,
    input  logic                  ren_we,
    input  logic [SRAM_INDEX-1:0] ren_addr,
    input  logic [SRAM_WIDTH-1:0] ren_data,
    input  logic [SRAM_INDEX-1:0] cp_addr,
    input  logic [SRAM_WIDTH-1:0] cp_data,
    output logic                  rmt_we,
    output logic [SRAM_INDEX-1:0] rmt_addr,
    output logic [SRAM_WIDTH-1:0] rmt_data
);

    // Per-port 2:1 select; a blocked port never writes regardless of source.
    always_comb begin
        rmt_we   = 1'b0;
        rmt_addr = ren_addr;
        rmt_data = ren_data;
        if (wr_block) begin
            rmt_we = 1'b0;
        end else if (copy_sel) begin
            rmt_we   = 1'b1;
            rmt_addr = cp_addr;
            rmt_data = cp_data;
        end else begin
            rmt_we = ren_we;
        end
    end

endmodule

// File: rtl/rmt_recovery_ctrl.sv
// RMT write-port sequencer: forwards rename updates, or on recovery copies
// the AMT into the RMT four entries per cycle while stalling rename.
module rmt_recovery_ctrl
    import rmt_recovery_ctrl_pkg::*;
#(
    parameter int SRAM_DEPTH = 16,
    parameter int SRAM_INDEX = 4,
    parameter int SRAM_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  recover_i,
    input  logic                  ren_we0_i,
    input  logic                  ren_we1_i,
    input  logic                  ren_we2_i,
    input  logic                  ren_we3_i,
    input  logic [SRAM_INDEX-1:0] ren_addr0_i,
    input  logic [SRAM_INDEX-1:0] ren_addr1_i,
    input  logic [SRAM_INDEX-1:0] ren_addr2_i,
    input  logic [SRAM_INDEX-1:0] ren_addr3_i,
    input  logic [SRAM_WIDTH-1:0] ren_data0_i,
    input  logic [SRAM_WIDTH-1:0] ren_data1_i,
    input  logic [SRAM_WIDTH-1:0] ren_data2_i,
    input  logic [SRAM_WIDTH-1:0] ren_data3_i,
    output logic [SRAM_INDEX-1:0] amt_addr0_o,
    output logic [SRAM_INDEX-1:0] amt_addr1_o,
    output logic [SRAM_INDEX-1:0] amt_addr2_o,
    output logic [SRAM_INDEX-1:0] amt_addr3_o,
    input  logic [SRAM_WIDTH-1:0] amt_data0_i,
    input  logic [SRAM_WIDTH-1:0] amt_data1_i,
    input  logic [SRAM_WIDTH-1:0] amt_data2_i,
    input  logic [SRAM_WIDTH-1:0] amt_data3_i,
    output logic                  rmt_we0_o,
    output logic                  rmt_we1_o,
    output logic                  rmt_we2_o,
    output logic                  rmt_we3_o,
    output logic [SRAM_INDEX-1:0] rmt_addr0_o,
    output logic [SRAM_INDEX-1:0] rmt_addr1_o,
    output logic [SRAM_INDEX-1:0] rmt_addr2_o,
    output logic [SRAM_INDEX-1:0] rmt_addr3_o,
    output logic [SRAM_WIDTH-1:0] rmt_data0_o,
    output logic [SRAM_WIDTH-1:0] rmt_data1_o,
    output logic [SRAM_WIDTH-1:0] rmt_data2_o,
    output logic [SRAM_WIDTH-1:0] rmt_data3_o,
    output logic                  stall_o,
    output logic                  recover_done_o
);

    localparam int BEAT_W = beat_bits(SRAM_DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SRAM_DEPTH / RMT_WR_PORTS - 1);

    rmt_state_e        state_r;
    rmt_state_e        state_s;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_s;
    logic              done_r;
    logic              done_s;
    logic              copy_s;
    logic              block_s;
    logic              stall_s;

    logic [SRAM_INDEX-1:0] beat_base_s;

    logic                  ren_we_s   [RMT_WR_PORTS];
    logic [SRAM_INDEX-1:0] ren_addr_s [RMT_WR_PORTS];
    logic [SRAM_WIDTH-1:0] ren_data_s [RMT_WR_PORTS];
    logic [SRAM_WIDTH-1:0] amt_data_s [RMT_WR_PORTS];
    logic [SRAM_INDEX-1:0] cp_addr_s  [RMT_WR_PORTS];
    logic [SRAM_INDEX-1:0] amt_addr_s [RMT_WR_PORTS];
    logic                  rmt_we_s   [RMT_WR_PORTS];
    logic [SRAM_INDEX-1:0] rmt_addr_s [RMT_WR_PORTS];
    logic [SRAM_WIDTH-1:0] rmt_data_s [RMT_WR_PORTS];

    assign ren_we_s   = '{ren_we0_i, ren_we1_i, ren_we2_i, ren_we3_i};
    assign ren_addr_s = '{ren_addr0_i, ren_addr1_i, ren_addr2_i, ren_addr3_i};
    assign ren_data_s = '{ren_data0_i, ren_data1_i, ren_data2_i, ren_data3_i};
    assign amt_data_s = '{amt_data0_i, amt_data1_i, amt_data2_i, amt_data3_i};

    // First entry of the current beat: 4*beat_q, in address width.
    assign beat_base_s = SRAM_INDEX'({beat_q, 2'b00});

    // State register, beat counter and the registered done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            beat_q  <= {BEAT_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            beat_q  <= beat_s;
            done_r  <= done_s;
        end
    end

    // Next-state, beat sequencing and port-takeover controls.
    always_comb begin
        state_s = state_r;
        beat_s  = beat_q;
        done_s  = 1'b0;
        copy_s  = 1'b0;
        block_s = 1'b0;
        stall_s = 1'b0;
        if (reset) begin
            // Quiesce the RMT ports while reset is held; rename is not stalled.
            block_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (recover_i) begin
                        block_s = 1'b1;
                        stall_s = 1'b1;
                        state_s = ST_COPY;
                        beat_s  = {BEAT_W{1'b0}};
                    end else begin
                        block_s = 1'b0;
                    end
                end
                ST_COPY: begin
                    copy_s  = 1'b1;
                    stall_s = 1'b1;
                    if (recover_i) begin
                        // Restart: this beat still writes, but the AMT may have moved on.
                        beat_s = {BEAT_W{1'b0}};
                    end else if (beat_q == LAST_BEAT) begin
                        state_s = ST_IDLE;
                        beat_s  = {BEAT_W{1'b0}};
                        done_s  = 1'b1;
                    end else begin
                        beat_s = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    beat_s  = {BEAT_W{1'b0}};
                    block_s = 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < RMT_WR_PORTS; k++) begin : g_port
        assign cp_addr_s[k]  = beat_base_s + SRAM_INDEX'(k);
        assign amt_addr_s[k] = copy_s ? cp_addr_s[k] : {SRAM_INDEX{1'b0}};

        rmt_wr_mux #(
            .SRAM_INDEX (SRAM_INDEX),
            .SRAM_WIDTH (SRAM_WIDTH)
        ) u_wr_mux (
            .copy_sel (copy_s),
            .wr_block (block_s),
            .ren_we   (ren_we_s[k]),
            .ren_addr (ren_addr_s[k]),
            .ren_data (ren_data_s[k]),
            .cp_addr  (cp_addr_s[k]),
            .cp_data  (amt_data_s[k]),
            .rmt_we   (rmt_we_s[k]),
            .rmt_addr (rmt_addr_s[k]),
            .rmt_data (rmt_data_s[k])
        );
    end

    assign amt_addr0_o = amt_addr_s[0];
    assign amt_addr1_o = amt_addr_s[1];
    assign amt_addr2_o = amt_addr_s[2];
    assign amt_addr3_o = amt_addr_s[3];

    assign rmt_we0_o   = rmt_we_s[0];
    assign rmt_we1_o   = rmt_we_s[1];
    assign rmt_we2_o   = rmt_we_s[2];
    assign rmt_we3_o   = rmt_we_s[3];
    assign rmt_addr0_o = rmt_addr_s[0];
    assign rmt_addr1_o = rmt_addr_s[1];
    assign rmt_addr2_o = rmt_addr_s[2];
    assign rmt_addr3_o = rmt_addr_s[3];
    assign rmt_data0_o = rmt_data_s[0];
    assign rmt_data1_o = rmt_data_s[1];
    assign rmt_data2_o = rmt_data_s[2];
    assign rmt_data3_o = rmt_data_s[3];

    assign stall_o        = stall_s;
    assign recover_done_o = done_r;

endmodule
